// File: rtl/ser_tx_framer_if.sv
// Valid/ready word stream feeding the TX framer FIFO.
// The master drives data/valid and the slave returns ready.
interface ser_tx_framer_if;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ser_tx_framer.sv
// TX framing stage ahead of the 32-bit serializer: input FIFO, per-frame load strobe,
// payload/IDLE/SYNC word selection. Optional frame counters under `TXF_STATS_EN.
module ser_tx_framer #(
  parameter int unsigned FRAME_LEN   = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] SYNC_WORD   = 32'hA5C3_3C5A,
  parameter logic [31:0] IDLE_WORD   = 32'h0000_0000,
  parameter int unsigned SYNC_PERIOD = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  ser_tx_framer_if.slave                s_if,
  output logic [31:0]                   o_ser_din,
  output logic                          o_ser_load,
  output logic                          o_frame_is_sync,
`ifdef TXF_STATS_EN
  output logic [15:0]                   o_stat_data,
  output logic [15:0]                   o_stat_idle,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned CntW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = PtrW + 1;
  localparam int unsigned SyncW  = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

  typedef enum logic [0:0] {StOff, StRun} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [SyncW-1:0]   r_sync_cnt;
  logic [31:0]        r_ser_din;
  logic               r_ser_load;
  logic               r_frame_is_sync;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]    r_wr_ptr;
  logic [PtrW-1:0]    r_rd_ptr;
  logic [LevelW-1:0]  r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_fs;
  logic w_sync_due;
  logic w_send_sync;
  logic w_pop;

  assign w_full      = (r_level == LevelW'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign s_if.ready  = !w_full;
  assign w_push      = s_if.valid && !w_full;

  // Enable low overrides a pending frame start; the next FS is the one out of StOff.
  assign w_fs        = i_enable && ((r_state == StOff) || (r_cnt == CntW'(FRAME_LEN - 1)));
  assign w_sync_due  = (SYNC_PERIOD != 0) && (r_sync_cnt == SyncW'(SYNC_PERIOD - 1));
  assign w_send_sync = (r_state == StOff) || w_sync_due;
  assign w_pop       = w_fs && !w_send_sync && !w_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_if.data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      // Push needs !full and pop needs !empty, so the level stays within 0..FIFO_DEPTH.
      if (w_push && !w_pop) begin
        r_level <= r_level + LevelW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LevelW'(1);
      end
    end
  end

`ifdef TXF_STATS_EN
  logic [15:0] r_stat_data;
  logic [15:0] r_stat_idle;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= StOff;
      r_cnt           <= '0;
      r_sync_cnt      <= '0;
      r_ser_din       <= '0;
      r_ser_load      <= 1'b0;
      r_frame_is_sync <= 1'b0;
`ifdef TXF_STATS_EN
      r_stat_data     <= '0;
      r_stat_idle     <= '0;
`endif
    end else begin
      r_ser_load <= 1'b0;
      if (!i_enable) begin
        r_state <= StOff;
        r_cnt   <= '0;
      end else if (w_fs) begin
        r_state    <= StRun;
        r_cnt      <= '0;
        r_ser_load <= 1'b1;
        if (w_send_sync) begin
          r_ser_din       <= SYNC_WORD;
          r_frame_is_sync <= 1'b1;
          r_sync_cnt      <= '0;
        end else begin
          r_frame_is_sync <= 1'b0;
          r_sync_cnt      <= r_sync_cnt + SyncW'(1);
          if (!w_empty) begin
            r_ser_din <= r_mem[r_rd_ptr];
`ifdef TXF_STATS_EN
            if (r_stat_data != 16'hFFFF) r_stat_data <= r_stat_data + 16'd1;
`endif
          end else begin
            r_ser_din <= IDLE_WORD;
`ifdef TXF_STATS_EN
            if (r_stat_idle != 16'hFFFF) r_stat_idle <= r_stat_idle + 16'd1;
`endif
          end
        end
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_ser_din       = r_ser_din;
  assign o_ser_load      = r_ser_load;
  assign o_frame_is_sync = r_frame_is_sync;
  assign o_fifo_level    = r_level;
`ifdef TXF_STATS_EN
  assign o_stat_data     = r_stat_data;
  assign o_stat_idle     = r_stat_idle;
`endif

endmodule

// File: tb/tb_ser_tx_framer.sv
// Directed bench for ser_tx_framer (default build): reset, framing cadence, FIFO order,
// full backpressure, periodic SYNC, mid-frame disable and mid-frame reset.
module tb_ser_tx_framer;
  localparam logic [31:0] Sync = 32'hA5C3_3C5A;
  localparam logic [31:0] Idle = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] ser_din;
  logic        ser_load;
  logic        frame_is_sync;
  logic [2:0]  fifo_level;

  int n_tests;
  int n_fail;
  logic [31:0] src [$];

  ser_tx_framer_if u_if ();

  ser_tx_framer u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .s_if            (u_if.slave),
    .o_ser_din       (ser_din),
    .o_ser_load      (ser_load),
    .o_frame_is_sync (frame_is_sync),
    .o_fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; the source queue drives the stream and drops a word once it is accepted.
  task automatic tick();
    bit acc;
    acc = u_if.valid && u_if.ready;
    @(posedge clk);
    #1;
    if (acc) void'(src.pop_front());
    u_if.valid = (src.size() != 0);
    u_if.data  = (src.size() != 0) ? src[0] : 32'h0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    src.delete();
    u_if.valid = 1'b0;
    u_if.data  = 32'h0;
    enable     = 1'b0;
    rst        = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  // Ticks until ser_load is seen (bounded); n is the number of ticks taken.
  task automatic wait_load(output int n);
    n = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (ser_load === 1'b1) begin
        n = k;
        break;
      end
    end
    n_tests++;
    if (n == 0) begin
      n_fail++;
      $display("FAIL wait_load: no ser_load within 70 cycles (got 0, need 1)");
    end
  endtask

  task automatic chk_frame(input string name, input logic [31:0] din, input logic sync);
    n_tests++;
    if (ser_din !== din || frame_is_sync !== sync || ser_load !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: din=%h sync=%b load=%b, need din=%h sync=%b load=1",
               name, ser_din, frame_is_sync, ser_load, din, sync);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (ser_din !== 32'h0 || ser_load !== 1'b0 || frame_is_sync !== 1'b0 ||
        u_if.ready !== 1'b1 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: din=%h load=%b sync=%b ready=%b level=%0d, need 0/0/0/1/0",
               ser_din, ser_load, frame_is_sync, u_if.ready, fifo_level);
    end
  endtask

  task automatic test_idle_frames();
    enable = 1'b1;
    tick();
    chk_frame("first_sync", Sync, 1'b1);
    for (int i = 0; i < 64; i++) begin
      tick();
      n_tests++;
      if (ser_load !== ((i == 31) || (i == 63))) begin
        n_fail++;
        $display("FAIL load_cadence[%0d]: load=%b, need %b", i, ser_load, (i == 31) || (i == 63));
      end
    end
    chk_frame("idle_frame", Idle, 1'b0);
  endtask

  task automatic test_payload();
    logic [31:0] held;
    int n;
    src.push_back(32'h1234_5678);
    u_if.valid = 1'b1;
    u_if.data  = src[0];
    tick();
    n_tests++;
    if (fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL payload_level: level=%0d, need 1", fifo_level);
    end
    wait_load(n);
    chk_frame("payload", 32'h1234_5678, 1'b0);
    n_tests++;
    if (fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL payload_pop: level=%0d, need 0", fifo_level);
    end
    held = ser_din;
    for (int i = 0; i < 31; i++) begin
      tick();
      n_tests++;
      if (ser_load !== 1'b0 || ser_din !== held) begin
        n_fail++;
        $display("FAIL payload_hold[%0d]: load=%b din=%h, need 0 and %h", i, ser_load, ser_din, held);
      end
    end
    tick();
    chk_frame("after_payload_idle", Idle, 1'b0);
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp [7];
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) src.push_back(32'hB000_0000 + 32'(i));
    u_if.valid = 1'b1;
    u_if.data  = src[0];
    ticks(6);
    n_tests++;
    if (u_if.ready !== 1'b0 || fifo_level !== 3'd4 || src.size() != 1) begin
      n_fail++;
      $display("FAIL fifo_full: ready=%b level=%0d left=%0d, need 0/4/1",
               u_if.ready, fifo_level, src.size());
    end
    exp[0] = Sync;
    for (int i = 0; i < 5; i++) exp[i+1] = 32'hB000_0000 + 32'(i);
    exp[6] = Idle;
    enable = 1'b1;
    for (int f = 0; f < 7; f++) begin
      wait_load(n);
      chk_frame($sformatf("full_order[%0d]", f), exp[f], f == 0);
    end
  endtask

  task automatic test_periodic_sync();
    int n;
    int e;
    do_reset();
    for (int i = 0; i < 40; i++) src.push_back(32'hD000_0000 + 32'(i));
    u_if.valid = 1'b1;
    u_if.data  = src[0];
    enable = 1'b1;
    e = 0;
    for (int f = 0; f < 34; f++) begin
      wait_load(n);
      if (f % 16 == 0) begin
        chk_frame($sformatf("psync[%0d]", f), Sync, 1'b1);
      end else begin
        chk_frame($sformatf("pdata[%0d]", f), 32'hD000_0000 + 32'(e), 1'b0);
        e++;
      end
    end
  endtask

  task automatic test_disable_mid();
    int n;
    do_reset();
    src.push_back(32'hC000_0001);
    src.push_back(32'hC000_0002);
    src.push_back(32'hC000_0003);
    u_if.valid = 1'b1;
    u_if.data  = src[0];
    ticks(3);
    enable = 1'b1;
    wait_load(n);
    chk_frame("dis_sync0", Sync, 1'b1);
    wait_load(n);
    chk_frame("dis_w0", 32'hC000_0001, 1'b0);
    ticks(10);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (ser_load !== 1'b0 || ser_din !== 32'hC000_0001) begin
        n_fail++;
        $display("FAIL dis_hold[%0d]: load=%b din=%h, need 0 and c0000001", i, ser_load, ser_din);
      end
    end
    n_tests++;
    if (fifo_level !== 3'd2) begin
      n_fail++;
      $display("FAIL dis_level: level=%0d, need 2", fifo_level);
    end
    enable = 1'b1;
    tick();
    chk_frame("dis_resync", Sync, 1'b1);
    wait_load(n);
    n_tests++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL dis_cnt_restart: frame gap=%0d, need 32", n);
    end
    chk_frame("dis_w1", 32'hC000_0002, 1'b0);
    wait_load(n);
    chk_frame("dis_w2", 32'hC000_0003, 1'b0);
    wait_load(n);
    chk_frame("dis_idle", Idle, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    src.push_back(32'hE000_0001);
    src.push_back(32'hE000_0002);
    src.push_back(32'hE000_0003);
    u_if.valid = 1'b1;
    u_if.data  = src[0];
    ticks(3);
    enable = 1'b1;
    wait_load(n);
    ticks(5);
    n_tests++;
    if (fifo_level !== 3'd3) begin
      n_fail++;
      $display("FAIL rmid_pre_level: level=%0d, need 3", fifo_level);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (ser_din !== 32'h0 || ser_load !== 1'b0 || frame_is_sync !== 1'b0 ||
        u_if.ready !== 1'b1 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: din=%h load=%b sync=%b ready=%b level=%0d, need 0/0/0/1/0",
               ser_din, ser_load, frame_is_sync, u_if.ready, fifo_level);
    end
    rst = 1'b0;
    tick();
    chk_frame("rmid_sync_after", Sync, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    u_if.valid = 1'b0;
    u_if.data  = 32'h0;
    test_reset();
    test_idle_frames();
    test_payload();
    test_fifo_full();
    test_periodic_sync();
    test_disable_mid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
